// File: rtl/somatorio_arbiter_if.sv
// Bus between the requesters / somatorio_control (master side) and the round-robin arbiter (slave side).
// req is a level held until its done/err pulse; iniciar, pronto, erro, done, err and timeout are one-cycle pulses.
interface somatorio_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int SEL_W = 2
) ();
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             iniciar;
  logic             pronto;
  logic             erro;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] err;
  logic             timeout;

  modport master (
    output req, pronto, erro,
    input  gnt, sel, busy, iniciar, done, err, timeout
  );

  modport slave (
    input  req, pronto, erro,
    output gnt, sel, busy, iniciar, done, err, timeout
  );
endinterface

// File: rtl/somatorio_arbiter.sv
// Round-robin arbiter sharing one somatorio unit among N_REQ requesters (IDLE->LAUNCH->WAIT->RELEASE).
// Optional WAIT watchdog enabled by defining SOMATORIO_ARB_TIMEOUT_EN.
module somatorio_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  somatorio_arbiter_if.slave bus,
  output logic [1:0]        state_dbg
);

  if (SEL_W != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("somatorio_arbiter: inconsistent N_REQ/SEL_W/TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W:0]   scan_sum;
  logic [SEL_W-1:0] scan_idx;
  logic             found;
  logic [N_REQ-1:0] winner_oh;

`ifdef SOMATORIO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign state_dbg = state;
  assign next_ptr  = (bus.sel == SEL_W'(N_REQ - 1)) ? '0 : bus.sel + 1'b1;

  // Scan ptr, ptr+1, ... (mod N_REQ); first requester found wins.
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, ptr} + (SEL_W + 1)'(i);
      if (scan_sum >= (SEL_W + 1)'(N_REQ)) begin
        scan_sum = scan_sum - (SEL_W + 1)'(N_REQ);
      end
      scan_idx = scan_sum[SEL_W-1:0];
      if (!found && bus.req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      bus.gnt     <= '0;
      bus.sel     <= '0;
      bus.busy    <= 1'b0;
      bus.iniciar <= 1'b0;
      bus.done    <= '0;
      bus.err     <= '0;
      bus.timeout <= 1'b0;
`ifdef SOMATORIO_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      bus.done    <= '0;
      bus.err     <= '0;
      bus.timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            bus.gnt     <= winner_oh;
            bus.sel     <= winner;
            bus.busy    <= 1'b1;
            bus.iniciar <= 1'b1;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          bus.iniciar <= 1'b0;
          state       <= S_WAIT;
`ifdef SOMATORIO_ARB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        S_WAIT: begin
          // gnt is one-hot at bit sel, so it doubles as the pulse mask.
          if (bus.erro) begin
            bus.err <= bus.gnt;
            state   <= S_RELEASE;
          end else if (bus.pronto) begin
            bus.done <= bus.gnt;
            state    <= S_RELEASE;
          end
`ifdef SOMATORIO_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            bus.err     <= bus.gnt;
            bus.timeout <= 1'b1;
            state       <= S_RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          ptr      <= next_ptr;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
